// File: rtl/alioth_timer_pkg.sv
// rtl/alioth_timer_pkg.sv - register map, CTRL field layout and CTRL readback packing for the alioth timer
package alioth_timer_pkg;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_COUNT  = 2'd1,
    REG_CMP    = 2'd2,
    REG_STATUS = 2'd3
  } reg_sel_e;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_AUTO_RLD_BIT = 1;
  localparam int CTRL_IE_BIT       = 2;
  localparam int CTRL_CASCADE_BIT  = 4;
  localparam int CTRL_PSC_LSB      = 8;
  localparam int CTRL_PSC_MSB      = 15;
  localparam int STATUS_PEND_BIT   = 0;

  typedef struct packed {
    logic [7:0] psc;
    logic       cascade;
    logic       ie;
    logic       auto_rld;
    logic       en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_pack(input ctrl_t c);
    logic [31:0] v;
    v = '0;
    v[CTRL_PSC_MSB:CTRL_PSC_LSB] = c.psc;
    v[CTRL_CASCADE_BIT]          = c.cascade;
    v[CTRL_IE_BIT]               = c.ie;
    v[CTRL_AUTO_RLD_BIT]         = c.auto_rld;
    v[CTRL_EN_BIT]               = c.en;
    return v;
  endfunction

endpackage

// File: rtl/alioth_timer_ch.sv
// rtl/alioth_timer_ch.sv - one timer channel: prescaler, COUNT, CMP, PEND and tick/match logic
module alioth_timer_ch
  import alioth_timer_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter bit          CASCADE_OK = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_ctrl_i,
  input  logic             wr_count_i,
  input  logic             wr_cmp_i,
  input  logic             wr_status_i,
  input  logic [31:0]      wdata_i,
  input  logic             casc_tick_i,
  output logic             match_o,
  output logic [31:0]      ctrl_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] cmp_o,
  output logic             pend_o,
  output logic             ie_o
);

  ctrl_t            ctrl_q, ctrl_d;
  logic [7:0]       psc_cnt_q, psc_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] cmp_q, cmp_d;
  logic             pend_q, pend_d;
  logic             psc_hit, tick, match;
  logic             unused_wdata;

  assign unused_wdata = ^{wdata_i[31:16], wdata_i[7:5], wdata_i[3]};

  // A cascaded channel takes its tick from the previous channel's match instead of its prescaler.
  always_comb begin
    psc_hit = (psc_cnt_q == ctrl_q.psc);
    tick    = ctrl_q.en && (ctrl_q.cascade ? casc_tick_i : psc_hit);
    match   = tick && (count_q == cmp_q);
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    psc_cnt_d = psc_cnt_q;
    count_d   = count_q;
    cmp_d     = cmp_q;
    pend_d    = pend_q;

    if (ctrl_q.en && !ctrl_q.cascade) begin
      psc_cnt_d = psc_hit ? 8'd0 : psc_cnt_q + 8'd1;
    end

    if (tick) begin
      if (match) begin
        if (ctrl_q.auto_rld) count_d = '0;
        else                 ctrl_d.en = 1'b0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end

    if (wr_status_i && wdata_i[STATUS_PEND_BIT]) pend_d = 1'b0;
    if (match) pend_d = 1'b1;

    // Software writes land last so they override the tick update of the same register.
    if (wr_ctrl_i) begin
      ctrl_d.en       = wdata_i[CTRL_EN_BIT];
      ctrl_d.auto_rld = wdata_i[CTRL_AUTO_RLD_BIT];
      ctrl_d.ie       = wdata_i[CTRL_IE_BIT];
      ctrl_d.cascade  = CASCADE_OK && wdata_i[CTRL_CASCADE_BIT];
      ctrl_d.psc      = wdata_i[CTRL_PSC_MSB:CTRL_PSC_LSB];
      psc_cnt_d       = '0;
    end
    if (wr_count_i) count_d = wdata_i[CNT_W-1:0];
    if (wr_cmp_i)   cmp_d   = wdata_i[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      psc_cnt_q <= '0;
      count_q   <= '0;
      cmp_q     <= '0;
      pend_q    <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      psc_cnt_q <= psc_cnt_d;
      count_q   <= count_d;
      cmp_q     <= cmp_d;
      pend_q    <= pend_d;
    end
  end

  assign match_o = match;
  assign ctrl_o  = ctrl_pack(ctrl_q);
  assign count_o = count_q;
  assign cmp_o   = cmp_q;
  assign pend_o  = pend_q;
  assign ie_o    = ctrl_q.ie;

endmodule

// File: rtl/alioth_timer_mc.sv
// rtl/alioth_timer_mc.sv - multi-channel timer top: decode, read register, irq OR, cascade links
// Optional channel cascading is enabled by defining ALIOTH_TIMER_CASCADE_EN.
module alioth_timer_mc
  import alioth_timer_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic              rvalid_o,
  output logic [NUM_CH-1:0] irq_vec_o,
  output logic              irq_o
);

`ifdef ALIOTH_TIMER_CASCADE_EN
  localparam bit CASC_EN = 1'b1;
`else
  localparam bit CASC_EN = 1'b0;
`endif

  logic [ADDR_W-5:0] ch_idx;
  reg_sel_e          reg_sel;
  logic [NUM_CH-1:0] wr_ctrl, wr_count, wr_cmp, wr_status;
  logic [NUM_CH-1:0] match, casc, pend, ie;
  logic [31:0]       ctrl_rd  [NUM_CH];
  logic [CNT_W-1:0]  count_rd [NUM_CH];
  logic [CNT_W-1:0]  cmp_rd   [NUM_CH];
  logic [31:0]       rd_val;
  logic [31:0]       data_q, data_d;
  logic              rvalid_q, rvalid_d;
  logic [NUM_CH-1:0] irq_vec_q, irq_vec_d;
  logic              unused_top;

  assign ch_idx     = addr_i[ADDR_W-1:4];
  assign reg_sel    = reg_sel_e'(addr_i[3:2]);
  assign unused_top = ^{addr_i[1:0], match[NUM_CH-1]};

  // Channel indices beyond NUM_CH decode to nothing: writes vanish, reads return zero.
  always_comb begin
    wr_ctrl   = '0;
    wr_count  = '0;
    wr_cmp    = '0;
    wr_status = '0;
    rd_val    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(ch_idx) == i) begin
        if (req_i && we_i) begin
          wr_ctrl[i]   = (reg_sel == REG_CTRL);
          wr_count[i]  = (reg_sel == REG_COUNT);
          wr_cmp[i]    = (reg_sel == REG_CMP);
          wr_status[i] = (reg_sel == REG_STATUS);
        end
        case (reg_sel)
          REG_CTRL:   rd_val = ctrl_rd[i];
          REG_COUNT:  rd_val = 32'(count_rd[i]);
          REG_CMP:    rd_val = 32'(cmp_rd[i]);
          REG_STATUS: rd_val = {31'd0, pend[i]};
        endcase
      end
    end
  end

  always_comb begin
    rvalid_d  = req_i && !we_i;
    data_d    = rvalid_d ? rd_val : data_q;
    irq_vec_d = pend & ie;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      rvalid_q  <= 1'b0;
      irq_vec_q <= '0;
    end else begin
      data_q    <= data_d;
      rvalid_q  <= rvalid_d;
      irq_vec_q <= irq_vec_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    if (g == 0) begin : g_head
      assign casc[g] = 1'b0;
    end else begin : g_link
      assign casc[g] = match[g-1];
    end

    alioth_timer_ch #(
      .CNT_W      (CNT_W),
      .CASCADE_OK (CASC_EN && (g > 0))
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .wr_ctrl_i   (wr_ctrl[g]),
      .wr_count_i  (wr_count[g]),
      .wr_cmp_i    (wr_cmp[g]),
      .wr_status_i (wr_status[g]),
      .wdata_i     (data_i),
      .casc_tick_i (casc[g]),
      .match_o     (match[g]),
      .ctrl_o      (ctrl_rd[g]),
      .count_o     (count_rd[g]),
      .cmp_o       (cmp_rd[g]),
      .pend_o      (pend[g]),
      .ie_o        (ie[g])
    );
  end

  assign data_o    = data_q;
  assign rvalid_o  = rvalid_q;
  assign irq_vec_o = irq_vec_q;
  assign irq_o     = |irq_vec_q;

endmodule
